// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM state type, size helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Number of bytes moved for a size code (illegal code never reaches a transfer).
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Illegal size or natural-alignment violation; only the two low address bits matter.
  function automatic logic is_bad_req(input logic [1:0] sz, input logic [1:0] a_lo);
    is_bad_req = (sz == SZ_ILL) ||
                 ((sz == SZ_HALF) && a_lo[0]) ||
                 ((sz == SZ_WORD) && (a_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and byte-memory bus bundle for the load/store unit.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes; memory never stalls.
interface lsu_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // The unit itself: consumes requests and memory read data, drives everything else.
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // The environment: CPU side plus the byte-wide data memory.
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of right-justified assembled load data by access size.
// Latency: purely combinational.
// Backpressure: none.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Extend from bit 7 or 15; words pass through untouched.
  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'd0, data_i[7:0]}
                                   : {{24{data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = unsigned_i ? {16'd0, data_i[15:0]}
                                   : {{16{data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: serialises byte/half/word CPU accesses onto a byte-wide big-endian memory.
// Latency: accept at T -> error rsp T+1, store rsp T+N+1, load rsp T+N+2 (N = bytes).
// Backpressure: one request in flight; response held in RESP until rsp_ready, req_ready only in IDLE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  lsu_if.slave   bus
);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;   // store bytes left-justified, shifted out MSB first
  logic [1:0]        cnt_q, cnt_d;       // byte index k within the access
  logic [31:0]       asm_q, asm_d;       // load bytes shifted in, byte 0 ends up most significant
  logic              rd_pend_q, rd_pend_d; // a load byte arrives on mem_rdata this cycle
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] asm_next;
  logic [31:0] ext_data;
  logic [1:0]  last_idx;
  logic        in_xfer;

  assign asm_next = {asm_q[23:0], bus.mem_rdata};
  assign last_idx = 2'(size_bytes(size_q) - 3'd1);
  assign in_xfer  = (state_q == ST_XFER);

  lsu_extend u_extend (
    .data_i     (asm_next),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  // Next-state, request capture, byte sequencing and response formation.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    rd_pend_d = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;

    if (rd_pend_q) begin
      asm_d = asm_next;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          case (bus.req_size)
            SZ_BYTE: wdata_d = bus.req_wdata << 24;
            SZ_HALF: wdata_d = bus.req_wdata << 16;
            default: wdata_d = bus.req_wdata;
          endcase
          cnt_d   = 2'd0;
          asm_d   = 32'd0;
          rdata_d = 32'd0;
          if (is_bad_req(bus.req_size, bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_XFER;
          end
        end
      end

      ST_XFER: begin
        rd_pend_d = !write_q;
        wdata_d   = wdata_q << 8;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == last_idx) begin
          state_d = write_q ? ST_RESP : ST_WAIT;
        end
      end

      // Final load byte is on mem_rdata now; extend the complete value into the response.
      ST_WAIT: begin
        rdata_d = ext_data;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      cnt_q     <= 2'd0;
      asm_q     <= 32'd0;
      rd_pend_q <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // CPU-facing outputs straight from state and response registers.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Memory bus is quiet (all zero) outside XFER; address wraps naturally at ADDR_W bits.
  assign bus.mem_en    = in_xfer;
  assign bus.mem_we    = in_xfer && write_q;
  assign bus.mem_addr  = in_xfer ? (addr_q + ADDR_W'(cnt_q)) : '0;
  assign bus.mem_wdata = (in_xfer && write_q) ? wdata_q[31:24] : 8'd0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  CPU request present.
REQ-005 SHALL have port req_ready  out  1  unit accepts request.
REQ-006 SHALL have port req_write  in  1  1=store, 0=load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  CPU takes response.
REQ-013 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  out  1  misaligned or illegal-size request.
REQ-015 SHALL have ports mem_en (out 1), mem_we (out 1), mem_addr (out ADDR_W), mem_wdata (out 8), mem_rdata (in 8) driving a byte-wide synchronous data memory; mem_rdata valid the cycle after mem_en with mem_we=0.

Function
REQ-016 SHALL implement FSM states IDLE, XFER, WAIT, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL latch all req_* fields on the handshake edge (req_valid && req_ready); inputs ignored afterwards.
REQ-018 SHALL use N bytes = 1/2/4 for size 00/01/10; memory is big-endian: byte k at addr+k maps to data bits [8N-1-8k -: 8].
REQ-019 SHALL compute addr+k modulo 2^ADDR_W (wrap at top of space).
REQ-020 SHALL, in XFER, issue one byte per cycle for k=0..N-1: mem_en=1, mem_we=req_write, mem_addr=addr+k, mem_wdata=byte k for stores.
REQ-021 SHALL, on loads, capture mem_rdata in the cycle after each issue; WAIT holds one cycle to capture the final byte.
REQ-022 SHALL give latency, accept at edge T: XFER cycles T+1..T+N; store rsp_valid from T+N+1; load WAIT at T+N+1, rsp_valid from T+N+2.
REQ-023 SHALL treat size 11, half with addr[0]=1, word with addr[1:0]!=0 as errors: no mem_en, IDLE->RESP, rsp_valid from T+1, rsp_err=1, rsp_rdata=0.
REQ-024 SHALL extend loads: byte/half sign-extended from bit 7/15 unless req_unsigned; word unchanged.
REQ-025 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1; on that edge go to IDLE (req_ready=1 next cycle, no same-cycle re-accept).
REQ-026 SHALL drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 outside XFER.

Reset
REQ-027 SHALL on rst_n=0 immediately enter IDLE, clear byte counter and assembly register, abort any transfer mid-operation.
REQ-028 SHALL have reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all mem_* outputs 0.

Structure
REQ-029 SHALL take size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type from shared package lsu_pkg.
REQ-030 SHALL place sign/zero extension in one combinational sub-module lsu_extend; everything else in load_store_unit.

Verification
REQ-031 SHALL cover word store: addr 0x100, wdata 0xDEADBEEF -> 4 cycles writing DE,AD,BE,EF to 0x100..0x103, rsp_valid at T+5, rsp_err=0.
REQ-032 SHALL cover signed byte load: mem[0x203]=0x80, size 00, unsigned 0 -> rsp_rdata 0xFFFFFF80 at T+3; with unsigned 1 -> 0x00000080.
REQ-033 SHALL cover half load at 0x202 of bytes 0x12,0x34 -> rsp_rdata 0x00001234 at T+4; half at 0x203 -> rsp_err=1 at T+1, no mem_en.
REQ-034 SHALL cover backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0 throughout, IDLE one cycle after release.
REQ-035 SHALL cover wrap: byte store at 0xFFFFFFFF -> single access at 0xFFFFFFFF; rst_n pulsed low during word load XFER k=2 -> mem_en drops immediately, req_ready=1, rsp_valid=0, no response after release.
